// File: rtl/usb_line_activity_detect.sv
// Full-speed USB receive line monitor on the 48 MHz sample clock.
// Glitch-filters D+/D-, tracks idle/active/SE0/reset phases and pulses SOP, EOP and bus reset.
module usb_line_activity_detect #(
  parameter int EOP_MIN_SAMPLES = 5,
  parameter int RESET_SAMPLES   = 120,
  parameter int IDLE_J_SAMPLES  = 8
) (
  input  logic       clk48_i,
  input  logic       rst_ni,
  input  logic       dataInP_i,
  input  logic       dataInN_i,
  output logic [1:0] lineState_o,
  output logic       rxGotSignal_o,
  output logic       eopDetected_o,
  output logic       usbReset_o,
  output logic       usbResetActive_o,
  output logic       busIdle_o
);

  localparam int SE0_W = $clog2(RESET_SAMPLES + 1);
  localparam int J_W   = $clog2(IDLE_J_SAMPLES + 1);

  localparam logic [SE0_W-1:0] SE0_MAX     = SE0_W'(RESET_SAMPLES);
  localparam logic [SE0_W-1:0] SE0_EOP_MIN = SE0_W'(EOP_MIN_SAMPLES);
  localparam logic [SE0_W-1:0] SE0_ONE     = SE0_W'(1);
  localparam logic [J_W-1:0]   J_MAX       = J_W'(IDLE_J_SAMPLES);
  localparam logic [J_W-1:0]   J_ONE       = J_W'(1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_SE0    = 2'd2;
  localparam logic [1:0] ST_RESET  = 2'd3;

  function automatic logic [SE0_W-1:0] se0_inc(input logic [SE0_W-1:0] cnt);
    if (cnt >= SE0_MAX) begin
      return SE0_MAX;
    end else begin
      return cnt + SE0_ONE;
    end
  endfunction

  function automatic logic [J_W-1:0] j_inc(input logic [J_W-1:0] cnt);
    if (cnt >= J_MAX) begin
      return J_MAX;
    end else begin
      return cnt + J_ONE;
    end
  endfunction

  logic [1:0]       raw_s;
  logic [1:0]       prev_raw_r;
  logic [1:0]       filt_r;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [SE0_W-1:0] se0_cnt_r;
  logic [SE0_W-1:0] se0_cnt_nxt_s;
  logic [J_W-1:0]   j_cnt_r;
  logic [J_W-1:0]   j_cnt_nxt_s;
  logic             rx_got_nxt_s;
  logic             eop_nxt_s;
  logic             usb_reset_nxt_s;
  logic             rx_got_r;
  logic             eop_r;
  logic             usb_reset_r;
  logic             reset_active_r;
  logic             bus_idle_r;

  assign raw_s = {dataInP_i, dataInN_i};

  // A raw state must be seen on two consecutive edges before it reaches filt_r.
  always_ff @(posedge clk48_i) begin
    if (!rst_ni) begin
      prev_raw_r <= LS_J;
      filt_r     <= LS_J;
    end else begin
      prev_raw_r <= raw_s;
      if (raw_s == prev_raw_r) begin
        filt_r <= raw_s;
      end else begin
        filt_r <= filt_r;
      end
    end
  end

  // Bus phase decisions on the filtered line; the reset threshold is checked before any J exit.
  always_comb begin
    state_nxt_s     = state_r;
    se0_cnt_nxt_s   = se0_cnt_r;
    j_cnt_nxt_s     = {J_W{1'b0}};
    rx_got_nxt_s    = 1'b0;
    eop_nxt_s       = 1'b0;
    usb_reset_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((filt_r == LS_K) || (filt_r == LS_SE1)) begin
          state_nxt_s  = ST_ACTIVE;
          rx_got_nxt_s = 1'b1;
        end else if (filt_r == LS_SE0) begin
          state_nxt_s   = ST_SE0;
          se0_cnt_nxt_s = SE0_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (filt_r == LS_SE0) begin
          state_nxt_s   = ST_SE0;
          se0_cnt_nxt_s = SE0_ONE;
        end else if (filt_r == LS_J) begin
          j_cnt_nxt_s = j_inc(j_cnt_r);
          if (j_cnt_nxt_s >= J_MAX) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ACTIVE;
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_SE0: begin
        if (filt_r == LS_SE0) begin
          se0_cnt_nxt_s = se0_inc(se0_cnt_r);
        end else begin
          se0_cnt_nxt_s = se0_cnt_r;
        end
        if (se0_cnt_nxt_s >= SE0_MAX) begin
          state_nxt_s     = ST_RESET;
          usb_reset_nxt_s = 1'b1;
        end else if (filt_r == LS_J) begin
          // Too-short SE0 is treated as line noise inside the packet.
          if (se0_cnt_r >= SE0_EOP_MIN) begin
            state_nxt_s = ST_IDLE;
            eop_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_ACTIVE;
          end
        end else if (filt_r == LS_SE0) begin
          state_nxt_s = ST_SE0;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_RESET: begin
        if (filt_r == LS_J) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESET;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        se0_cnt_nxt_s = {SE0_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk48_i) begin
    if (!rst_ni) begin
      state_r        <= ST_IDLE;
      se0_cnt_r      <= {SE0_W{1'b0}};
      j_cnt_r        <= {J_W{1'b0}};
      rx_got_r       <= 1'b0;
      eop_r          <= 1'b0;
      usb_reset_r    <= 1'b0;
      reset_active_r <= 1'b0;
      bus_idle_r     <= 1'b1;
    end else begin
      state_r        <= state_nxt_s;
      se0_cnt_r      <= se0_cnt_nxt_s;
      j_cnt_r        <= j_cnt_nxt_s;
      rx_got_r       <= rx_got_nxt_s;
      eop_r          <= eop_nxt_s;
      usb_reset_r    <= usb_reset_nxt_s;
      reset_active_r <= (state_nxt_s == ST_RESET);
      bus_idle_r     <= (state_nxt_s == ST_IDLE);
    end
  end

  assign lineState_o      = filt_r;
  assign rxGotSignal_o    = rx_got_r;
  assign eopDetected_o    = eop_r;
  assign usbReset_o       = usb_reset_r;
  assign usbResetActive_o = reset_active_r;
  assign busIdle_o        = bus_idle_r;

endmodule

// File: tb/tb_usb_line_activity_detect.sv
// Bench for usb_line_activity_detect: directed scenarios plus random line traffic,
// every cycle checked against a phase-level reference model.
module tb_usb_line_activity_detect;

  localparam int EOP_MIN = 5;
  localparam int RST_LEN = 120;
  localparam int IDLE_J  = 8;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b11;

  localparam int P_IDLE = 0;
  localparam int P_ACT  = 1;
  localparam int P_SE0  = 2;
  localparam int P_RST  = 3;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       dp;
  logic       dn;
  logic [1:0] line_state;
  logic       rx_got;
  logic       eop;
  logic       usb_reset;
  logic       reset_active;
  logic       bus_idle;

  usb_line_activity_detect #(
    .EOP_MIN_SAMPLES(EOP_MIN),
    .RESET_SAMPLES  (RST_LEN),
    .IDLE_J_SAMPLES (IDLE_J)
  ) dut (
    .clk48_i         (clk),
    .rst_ni          (rst_ni),
    .dataInP_i       (dp),
    .dataInN_i       (dn),
    .lineState_o     (line_state),
    .rxGotSignal_o   (rx_got),
    .eopDetected_o   (eop),
    .usbReset_o      (usb_reset),
    .usbResetActive_o(reset_active),
    .busIdle_o       (bus_idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model: bus phase plus run lengths of filtered SE0 / J
  int         m_phase;
  logic [1:0] m_prev;
  logic [1:0] m_filt;
  int         m_se0_run;
  int         m_j_run;
  logic       e_rx, e_eop, e_rst;

  // observed pulse tallies for directed windows
  int rx_cnt, eop_cnt, rst_cnt;
  int rx_first, eop_first, rst_first;
  int c0;

  task automatic cmp_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic cmp_ls(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [1:0] r);
    logic [1:0] f;
    e_rx  = 1'b0;
    e_eop = 1'b0;
    e_rst = 1'b0;
    if (!rst) begin
      m_phase   = P_IDLE;
      m_prev    = LJ;
      m_filt    = LJ;
      m_se0_run = 0;
      m_j_run   = 0;
    end else begin
      f = m_filt;
      case (m_phase)
        P_IDLE: begin
          if (f == LK || f == L1) begin m_phase = P_ACT; m_j_run = 0; e_rx = 1'b1; end
          else if (f == L0) begin m_phase = P_SE0; m_se0_run = 1; end
        end
        P_ACT: begin
          if (f == L0) begin m_phase = P_SE0; m_se0_run = 1; end
          else if (f == LJ) begin
            m_j_run++;
            if (m_j_run >= IDLE_J) m_phase = P_IDLE;
          end else m_j_run = 0;
        end
        P_SE0: begin
          if (f == L0) begin
            if (m_se0_run < RST_LEN) m_se0_run++;
            if (m_se0_run >= RST_LEN) begin m_phase = P_RST; e_rst = 1'b1; end
          end else if (f == LJ) begin
            if (m_se0_run >= EOP_MIN) begin m_phase = P_IDLE; e_eop = 1'b1; end
            else begin m_phase = P_ACT; m_j_run = 0; end
          end else begin
            m_phase = P_ACT; m_j_run = 0;
          end
        end
        P_RST: if (f == LJ) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
      if (r == m_prev) m_filt = r;
      m_prev = r;
    end
  endtask

  task automatic tick(input logic rst, input logic [1:0] r);
    @(negedge clk);
    rst_ni = rst;
    dp     = r[1];
    dn     = r[0];
    @(posedge clk);
    model_edge(rst, r);
    cyc++;
    #1;
    cmp_ls ("lineState",      line_state,   m_filt);
    cmp_bit("rxGotSignal",    rx_got,       e_rx);
    cmp_bit("eopDetected",    eop,          e_eop);
    cmp_bit("usbReset",       usb_reset,    e_rst);
    cmp_bit("usbResetActive", reset_active, m_phase == P_RST);
    cmp_bit("busIdle",        bus_idle,     m_phase == P_IDLE);
    if (rx_got === 1'b1) begin rx_cnt++; if (rx_first < 0) rx_first = cyc; end
    if (eop === 1'b1) begin eop_cnt++; if (eop_first < 0) eop_first = cyc; end
    if (usb_reset === 1'b1) begin rst_cnt++; if (rst_first < 0) rst_first = cyc; end
  endtask

  task automatic run(input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, r);
  endtask

  task automatic clear_tally();
    rx_cnt = 0; eop_cnt = 0; rst_cnt = 0;
    rx_first = -1; eop_first = -1; rst_first = -1;
  endtask

  initial begin
    rst_ni = 1'b0;
    dp = 1'b1;
    dn = 1'b0;
    clear_tally();

    // reset, then quiet J
    tick(1'b0, LJ);
    tick(1'b0, LJ);
    clear_tally();
    run(LJ, 20);
    cmp_int("reset_quiet_pulses", rx_cnt + eop_cnt + rst_cnt, 0);

    // SOP latency and a full packet with an 8-sample EOP
    clear_tally();
    c0 = cyc + 1;
    run(LK, 4);
    cmp_int("sop_latency", rx_first - c0, 2);
    run(LJ, 4); run(LK, 4); run(LJ, 4); run(LK, 4);
    run(L0, 8);
    run(LJ, 10);
    cmp_int("pkt_rx_count", rx_cnt, 1);
    cmp_int("pkt_eop_count", eop_cnt, 1);

    // 4-sample SE0 is not an EOP; J run returns to idle silently
    clear_tally();
    run(LK, 4); run(LJ, 4); run(LK, 4);
    run(L0, 4);
    run(LJ, 12);
    cmp_int("short_se0_eop", eop_cnt, 0);
    cmp_int("short_se0_rx", rx_cnt, 1);
    cmp_bit("short_se0_idle", bus_idle, 1'b1);

    // single-sample glitches in idle
    clear_tally();
    run(LK, 1); run(LJ, 4); run(L0, 1); run(LJ, 4); run(L1, 1); run(LJ, 4);
    cmp_int("glitch_pulses", rx_cnt + eop_cnt + rst_cnt, 0);
    cmp_ls("glitch_line", line_state, LJ);

    // long SE0: bus reset
    clear_tally();
    c0 = cyc + 1;
    run(L0, 200);
    cmp_bit("reset_active_hold", reset_active, 1'b1);
    run(LJ, 4);
    cmp_int("busreset_count", rst_cnt, 1);
    cmp_int("busreset_latency", rst_first - c0, RST_LEN + 1);
    cmp_int("busreset_eop", eop_cnt, 0);
    cmp_bit("busreset_idle", bus_idle, 1'b1);

    // synchronous reset mid-packet
    run(LK, 4); run(LJ, 2);
    clear_tally();
    tick(1'b0, LK);
    cmp_ls("midpkt_rst_line", line_state, LJ);
    cmp_bit("midpkt_rst_idle", bus_idle, 1'b1);
    run(LJ, 4);
    // synchronous reset mid-SE0 (count 3)
    run(L0, 5);
    tick(1'b0, L0);
    cmp_bit("midse0_rst_idle", bus_idle, 1'b1);
    run(LJ, 4);
    cmp_int("mid_rst_pulses", rx_cnt + eop_cnt + rst_cnt, 0);
    clear_tally();
    run(LK, 4);
    cmp_int("post_rst_rx", rx_cnt, 1);

    // back-to-back EOP then new SOP
    run(LJ, 4);
    clear_tally();
    run(L0, 8); run(LJ, 2); run(LK, 4); run(LJ, 10);
    cmp_int("b2b_eop", eop_cnt, 1);
    cmp_int("b2b_rx", rx_cnt, 1);
    cmp_int("b2b_gap", rx_first - eop_first, 2);

    // random line traffic
    for (int s = 0; s < 300; s++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel < 6)       run(LJ, int'($urandom_range(1, 10)));
      else if (sel < 11) run(LK, int'($urandom_range(1, 6)));
      else if (sel < 12) run(L1, int'($urandom_range(1, 3)));
      else if (sel < 17) run(L0, int'($urandom_range(1, 10)));
      else if (sel < 18) run(L0, int'($urandom_range(110, 130)));
      else if (sel < 19) tick(1'b0, 2'($urandom_range(0, 3)));
      else               run(LJ, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
